// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small byte FIFO in front of a UART transmitter, LSB first, line idle high.
// Default build sends 8N1 frames; define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 435,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          uart_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   baud_cnt;
    logic [CW-1:0]   next_baud;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            bit_end;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = ~full;
    assign count     = wr_ptr - rd_ptr;
    assign push      = in_valid && !full;
    assign bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign next_baud = bit_end ? '0 : baud_cnt + CW'(1);

    // A byte leaves the FIFO when idle, or at the very end of a stop bit for a gapless next frame.
    assign pop = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // uart_out and busy are driven from the current state, so both lag the state by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            uart_out <= 1'b1;
            busy     <= 1'b0;
        end else begin
            busy <= (state != S_IDLE) || !empty;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                shreg  <= mem[rd_ptr[AW-1:0]];
            end
            case (state)
                S_IDLE: begin
                    uart_out <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!empty) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    uart_out <= 1'b0;
                    baud_cnt <= next_baud;
                    if (bit_end) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    uart_out <= shreg[bit_idx];
                    baud_cnt <= next_baud;
                    if (bit_end) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    uart_out <= ^shreg;
                    baud_cnt <= next_baud;
                    if (bit_end) begin
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    uart_out <= 1'b1;
                    baud_cnt <= next_baud;
                    if (bit_end) begin
                        state <= empty ? S_IDLE : S_START;
                    end
                end
                default: begin
                    uart_out <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: drives uart_tx_fifo with fixed and random bytes and checks the serial line
// cycle by cycle against frames built from the byte values; honours UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

    localparam int unsigned CPB   = 435;
    localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CPB;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [7:0]                in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic                      uart_out;
    logic                      busy;
    logic [$clog2(DEPTH):0]    count;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .uart_out (uart_out),
        .busy     (busy),
        .count    (count)
    );

    always #20 clk = ~clk;

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    // Expected line level for every bit slot of a frame carrying byte b.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        if (NBITS == 11) f[9] = ^b;
        return f;
    endfunction

    // Checks one whole frame; contiguous=1 means its start bit must begin on the next cycle.
    task automatic check_frame(input logic [7:0] b, input bit contiguous, input string name);
        logic [10:0] fb;
        int          t;
        fb = frame_bits(b);
        t  = 0;
        @(negedge clk);
        if (!contiguous) begin
            while (uart_out !== 1'b0 && t < 3 * FRAME) begin
                @(negedge clk);
                t++;
            end
            if (uart_out !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL %s start timeout: line=%b expected 0", name, uart_out);
                return;
            end
        end
        for (int k = 0; k < int'(NBITS); k++) begin
            logic bad;
            logic seen;
            int   bad_cyc;
            bad = 1'b0;
            seen = 1'b0;
            bad_cyc = 0;
            for (int c = 0; c < int'(CPB); c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (uart_out !== fb[k] && !bad) begin
                    bad = 1'b1;
                    seen = uart_out;
                    bad_cyc = c;
                end
            end
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL %s bit %0d cycle %0d: line=%b expected %b", name, k, bad_cyc, seen, fb[k]);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 2 * int'(FRAME)) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle timeout: busy=%b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        logic stray;
        logic s_line;
        logic s_busy;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(negedge clk);
        vectors += 4;
        if (uart_out !== 1'b1) begin miscompares++; $display("FAIL reset_line: got %b expected 1", uart_out); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        reset = 1'b0;
        // Pulse while idle.
        repeat (5) @(negedge clk);
        #5 reset = 1'b1;
        #1;
        vectors++;
        if (uart_out !== 1'b1 || busy !== 1'b0 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_idle: line=%b busy=%b count=%0d expected 1,0,0", uart_out, busy, count);
        end
        @(negedge clk);
        reset = 1'b0;
        // Pulse mid-frame with a second byte still queued.
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'h00;
        @(negedge clk);
        in_data = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (1000) @(negedge clk);
        vectors += 2;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_pre_busy: got %b expected 1", busy); end
        if (count !== 3'd1) begin miscompares++; $display("FAIL reset_pre_count: got %0d expected 1", count); end
        #5 reset = 1'b1;
        #1;
        vectors++;
        if (uart_out !== 1'b1 || busy !== 1'b0 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_frame: line=%b busy=%b count=%0d expected 1,0,0", uart_out, busy, count);
        end
        @(negedge clk);
        reset = 1'b0;
        stray = 1'b0;
        s_line = 1'b1;
        s_busy = 1'b0;
        for (int k = 0; k < int'(FRAME) + 20; k++) begin
            @(negedge clk);
            if ((uart_out !== 1'b1 || busy !== 1'b0) && !stray) begin
                stray = 1'b1;
                s_line = uart_out;
                s_busy = busy;
            end
        end
        vectors++;
        if (stray) begin
            miscompares++;
            $display("FAIL reset_stray: line=%b busy=%b after release, expected 1,0", s_line, s_busy);
        end
    endtask

    task automatic test_single(input logic [7:0] b, input string name);
        @(negedge clk);
        in_data = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
        vectors += 2;
        if (uart_out !== 1'b1) begin miscompares++; $display("FAIL %s line_after_push: got %b expected 1", name, uart_out); end
        if (count !== 3'd1) begin miscompares++; $display("FAIL %s count_after_push: got %0d expected 1", name, count); end
        @(negedge clk);
        vectors += 3;
        if (uart_out !== 1'b1) begin miscompares++; $display("FAIL %s line_after_pop: got %b expected 1", name, uart_out); end
        if (count !== 3'd0) begin miscompares++; $display("FAIL %s count_after_pop: got %0d expected 0", name, count); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL %s busy_after_pop: got %b expected 1", name, busy); end
        check_frame(b, 1'b1, name);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL %s busy_last_stop: got %b expected 1", name, busy); end
        @(negedge clk);
        vectors += 2;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL %s busy_fall: got %b expected 0", name, busy); end
        if (uart_out !== 1'b1) begin miscompares++; $display("FAIL %s line_idle: got %b expected 1", name, uart_out); end
    endtask

    // Pushes n bytes on consecutive cycles from idle; the first leaves for the shifter
    // one cycle after it is accepted, so the FIFO holds min(i, DEPTH) after push i>0.
    task automatic push_burst(input logic [7:0] bytes [12], input int n, input string name);
        int exp_cnt;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = bytes[0];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_cnt = (i == 0) ? 1 : ((i < int'(DEPTH)) ? i : int'(DEPTH));
            vectors += 2;
            if (count !== 3'(exp_cnt)) begin
                miscompares++;
                $display("FAIL %s count push %0d: got %0d expected %0d", name, i, count, exp_cnt);
            end
            if (in_ready !== (exp_cnt < int'(DEPTH))) begin
                miscompares++;
                $display("FAIL %s in_ready push %0d: got %b expected %b", name, i, in_ready, exp_cnt < int'(DEPTH));
            end
            if (i < n - 1) in_data = bytes[i+1];
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [12];
        bytes = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        fork
            push_burst(bytes, 5, "b2b");
            begin
                check_frame(bytes[0], 1'b0, "b2b_f0");
                for (int i = 1; i < 5; i++) check_frame(bytes[i], 1'b1, $sformatf("b2b_f%0d", i));
            end
        join
        wait_idle("b2b");
    endtask

    // in_valid held for 12 cycles with fresh data each cycle; only DEPTH+1 bytes can be taken.
    task automatic test_full_hold();
        logic [7:0] bytes [12];
        for (int i = 0; i < 12; i++) bytes[i] = 8'($urandom);
        fork
            push_burst(bytes, 12, "hold");
            begin
                check_frame(bytes[0], 1'b0, "hold_f0");
                for (int i = 1; i <= int'(DEPTH); i++) check_frame(bytes[i], 1'b1, $sformatf("hold_f%0d", i));
            end
        join
        wait_idle("hold");
    endtask

    // Third byte pushed on exactly the clock where the second is popped at the end of stop.
    task automatic test_push_pop_boundary();
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
        x = 8'($urandom);
        y = 8'($urandom);
        z = 8'($urandom);
        fork
            begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data = x;
                @(negedge clk);
                in_data = y;
                @(negedge clk);
                in_valid = 1'b0;
                repeat (FRAME - 1) @(negedge clk);
                vectors++;
                if (count !== 3'd1) begin miscompares++; $display("FAIL boundary count_before: got %0d expected 1", count); end
                in_valid = 1'b1;
                in_data = z;
                @(negedge clk);
                in_valid = 1'b0;
                in_data = 8'($urandom);
                vectors += 2;
                if (count !== 3'd1) begin miscompares++; $display("FAIL boundary count_after: got %0d expected 1", count); end
                if (in_ready !== 1'b1) begin miscompares++; $display("FAIL boundary in_ready: got %b expected 1", in_ready); end
            end
            begin
                check_frame(x, 1'b0, "boundary_x");
                check_frame(y, 1'b1, "boundary_y");
                check_frame(z, 1'b1, "boundary_z");
            end
        join
        wait_idle("boundary");
    endtask

    initial begin
        test_reset();
        test_single(8'h41, "single_41");
        test_back_to_back();
        test_full_hold();
        test_push_pop_boundary();
`ifdef UART_TX_PARITY_EN
        test_single(8'h07, "parity_07");
        test_single(8'h03, "parity_03");
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
